// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, master FSM states and burst helper functions.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_LAST = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Number of beats a burst carries; undefined-length INCR uses the request length.
    function automatic logic [4:0] beats_of(input logic [2:0] hburst, input logic [4:0] len);
        logic [4:0] beats;
        case (hburst)
            HBURST_SINGLE:               beats = 5'd1;
            HBURST_INCR:                 beats = (len == 5'd0) ? 5'd1 : len;
            HBURST_WRAP4, HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  beats = 5'd8;
            default:                     beats = 5'd16;
        endcase
        return beats;
    endfunction

    // Wrapping bursts are the even, non-SINGLE codes.
    function automatic logic is_wrap(input logic [2:0] hburst);
        return (hburst[0] == 1'b0) && (hburst != HBURST_SINGLE);
    endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Next beat address for word bursts: linear for INCR types, wrapped inside
// a beats*4 byte window for WRAP types.
module ahb_burst_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        hburst,
    input  logic [4:0]        beats,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    // Select linear or wrapped increment of the current word address.
    always_comb begin
        incr_addr = addr + ADDR_W'(4);
        wrap_mask = ADDR_W'({beats, 2'b00}) - ADDR_W'(1);
        if (is_wrap(hburst)) begin
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end else begin
            next_addr = incr_addr;
        end
    end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite burst master: turns one controller command into a pipelined
// NONSEQ/SEQ burst, handles wait states and the two-cycle ERROR response.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [4:0]        cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [1:0]        htrans,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [4:0]        beats_q, beats_d;
    logic [4:0]        beats_left_q, beats_left_d;   // beats still to be addressed
    logic              dphase_q, dphase_d;           // a data phase is in flight
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [4:0]        beats_cmd;
    logic [ADDR_W-1:0] next_addr;

    ahb_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (haddr_q),
        .hburst    (hburst_q),
        .beats     (beats_q),
        .next_addr (next_addr)
    );

    assign beats_cmd = beats_of(cmd_burst, cmd_len);

    // Next-state and registered-output computation; hready=0 leaves everything held.
    always_comb begin
        state_d      = state_q;
        haddr_d      = haddr_q;
        htrans_d     = htrans_q;
        hwrite_d     = hwrite_q;
        hburst_d     = hburst_q;
        hwdata_d     = hwdata_q;
        beats_d      = beats_q;
        beats_left_d = beats_left_q;
        dphase_d     = dphase_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        wr_data_req  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    haddr_d      = cmd_addr & ~ADDR_W'(3);
                    htrans_d     = HTRANS_NONSEQ;
                    hwrite_d     = cmd_write;
                    hburst_d     = cmd_burst;
                    beats_d      = beats_cmd;
                    beats_left_d = beats_cmd - 5'd1;
                    dphase_d     = 1'b0;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    if (dphase_q && !hwrite_q && hresp == HRESP_OKAY) begin
                        rd_data_d  = hrdata;
                        rd_valid_d = 1'b1;
                    end
                    if (hwrite_q) begin
                        wr_data_req = 1'b1;
                        hwdata_d    = wr_data;
                    end
                    dphase_d = 1'b1;
                    if (beats_left_q != 5'd0) begin
                        htrans_d     = HTRANS_SEQ;
                        haddr_d      = next_addr;
                        beats_left_d = beats_left_q - 5'd1;
                    end else begin
                        htrans_d = HTRANS_IDLE;
                        state_d  = ST_LAST;
                    end
                end else if (dphase_q && hresp == HRESP_ERROR) begin
                    // First ERROR cycle: withdraw any pending SEQ.
                    htrans_d = HTRANS_IDLE;
                    state_d  = ST_ERR;
                end
            end
            ST_LAST: begin
                if (hready) begin
                    if (!hwrite_q && hresp == HRESP_OKAY) begin
                        rd_data_d  = hrdata;
                        rd_valid_d = 1'b1;
                    end
                    done_d   = 1'b1;
                    dphase_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (hresp == HRESP_ERROR) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (hready) begin
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    dphase_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            haddr_q      <= '0;
            htrans_q     <= HTRANS_IDLE;
            hwrite_q     <= 1'b0;
            hburst_q     <= HBURST_SINGLE;
            hwdata_q     <= '0;
            beats_q      <= 5'd1;
            beats_left_q <= 5'd0;
            dphase_q     <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            hburst_q     <= hburst_d;
            hwdata_q     <= hwdata_d;
            beats_q      <= beats_d;
            beats_left_q <= beats_left_d;
            dphase_q     <= dphase_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hburst    = hburst_q;
    assign hwdata    = hwdata_q;
    assign hsize     = HSIZE_WORD;
    assign hprot     = HPROT_DEFAULT;
    assign hmastlock = 1'b0;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
